// File: rtl/fetch_unit.sv
// Multicycle instruction-fetch stage: owns the PC, fetches over a req/ack
// handshake, holds the word for decode and computes the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic [31:0] sign_ext_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, ERROR} state_t;

  state_t      state;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] next_pc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Shifting in 32 bits drops imm[31:30]; the add wraps modulo 2^32.
  always_comb begin
    br_target  = pc_plus4 + (sign_ext_imm << 2);
    jmp_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    next_pc    = pc_plus4;
    if (jump_reg)          next_pc = reg_target;
    else if (jump)         next_pc = jmp_target;
    else if (branch_taken) next_pc = br_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      addr_err    <= 1'b0;
      retired     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            retired     <= retired + 32'd1;
            // A misaligned target retires the instruction but leaves pc alone.
            if (next_pc[1:0] != 2'b00) begin
              addr_err <= 1'b1;
              state    <= ERROR;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        ERROR: begin
          addr_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch/jump priority,
// stalls, misaligned JR and reset during fetch.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = 32'd0;
  logic [31:0] sign_ext_imm = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_ret = 32'd0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
    .reg_target(reg_target), .sign_ext_imm(sign_ext_imm),
    .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serve one fetch after 'waits' cycles of withheld ack.
  task automatic fetch(input logic [31:0] word, input logic [31:0] addr, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("instr", instr, word);
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic accept(input logic br, input logic j, input logic jr,
                        input logic [31:0] tgt, input logic [31:0] imm);
    branch_taken = br; jump = j; jump_reg = jr;
    reg_target = tgt; sign_ext_imm = imm;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    reg_target = 32'h0; sign_ext_imm = 32'h0;
    exp_ret = exp_ret + 32'd1;
    chk("retired", retired, exp_ret);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_ret", retired, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Sequential fetch
    fetch(32'h2002_0005, 32'h0, 0);
    accept(0, 0, 0, 32'h0, 32'h0);
    chk("seq_pc4", pc, 32'h4);
    fetch(32'h2003_0007, 32'h4, 0);
    accept(0, 0, 0, 32'h0, 32'h1234);
    chk("seq_pc8", pc, 32'h8);
    chk("seq_ret2", retired, 32'd2);

    // Branches from pc=0x10
    fetch(32'h0, 32'h8, 0);
    accept(0, 0, 1, 32'h10, 32'h0);
    chk("jr_pc10", pc, 32'h10);
    fetch(32'h1000_FFFF, 32'h10, 0);
    accept(1, 0, 0, 32'h0, 32'hFFFF_FFFC);
    chk("br_neg", pc, 32'h4);  // 0x14 - 16
    fetch(32'h0, 32'h4, 0);
    accept(0, 0, 1, 32'h10, 32'h0);
    fetch(32'h1000_0003, 32'h10, 0);
    accept(1, 0, 0, 32'h0, 32'h0000_0003);
    chk("br_pos", pc, 32'h20);
    fetch(32'h0, 32'h20, 0);
    accept(1, 0, 0, 32'h0, 32'hC000_0001);  // top imm bits dropped
    chk("br_drop", pc, 32'h28);

    // Jump priority at pc=0x1000_0000
    fetch(32'h0, 32'h28, 0);
    accept(0, 0, 1, 32'h1000_0000, 32'h0);
    fetch(32'h0800_0040, 32'h1000_0000, 0);
    accept(1, 1, 0, 32'h0, 32'h0000_0100);
    chk("jump", pc, 32'h1000_0100);
    fetch(32'h0, 32'h1000_0100, 0);
    accept(0, 0, 1, 32'h1000_0000, 32'h0);
    fetch(32'h0800_0040, 32'h1000_0000, 0);
    accept(1, 1, 1, 32'h0000_0200, 32'h0000_0100);
    chk("jr_prio", pc, 32'h200);

    // pc_plus4 wrap
    fetch(32'h0, 32'h200, 0);
    accept(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    chk("wrap_p4", pc_plus4, 32'h0);
    fetch(32'h0, 32'hFFFF_FFFC, 0);
    accept(0, 0, 0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Stalls: 3-cycle ack delay, then 5 cycles without instr_ready
    fetch(32'hCAFE_0001, 32'h0, 3);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_instr", instr, 32'hCAFE_0001);
      chk("hold_pc", pc, 32'h0);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    accept(0, 0, 0, 32'h0, 32'h0);
    chk("stall_pc", pc, 32'h4);

    // Misaligned JR
    fetch(32'h0, 32'h4, 0);
    accept(0, 0, 1, 32'h0000_0102, 32'h0);
    chk("mis_err", {31'd0, addr_err}, 32'd1);
    chk("mis_pc", pc, 32'h4);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_pc", pc, 32'h4);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    chk("err_ret", retired, exp_ret);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_err", {31'd0, addr_err}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_ret", retired, 32'd0);
    exp_ret = 32'd0;

    // Reset mid-fetch, late ack lands in IDLE
    tick();
    reset_n = 1'b1;
    tick();
    chk("mf_req", {31'd0, imem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mf_req_rst", {31'd0, imem_req}, 32'd0);
    tick();
    reset_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h7777_7777;
    tick();
    imem_ack = 1'b0;
    chk("late_instr", instr, 32'h0);
    chk("late_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_req", {31'd0, imem_req}, 32'd1);
    chk("late_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
